radix_booth_mult: RTL and testbench
===================================

Name: radix_booth_mult

Overview:
- Sequential signed multiplier using radix-4 (modified) Booth recoding.
- Takes two WIDTH-bit two's-complement operands and produces a 2*WIDTH-bit signed product.
- Retires one Booth digit (2 multiplier bits) per enabled clock.
- Used as a multi-cycle arithmetic unit. The host loads operands, releases load, then reads OUT after completion.

Parameters:
- WIDTH, 32, operand width in bits. Must be even and at least 4.

Ports:
- clk   input  1        rising-edge clock
- rst   input  1        asynchronous, active-low reset
- en    input  1        step enable; iteration advances only when high
- load  input  1        operand load / restart request
- A     input  WIDTH    signed multiplicand
- B     input  WIDTH    signed multiplier
- OUT   output 2*WIDTH  signed product, registered

Behaviour:
- Reset (rst=0, asynchronous): clear all state.
  - OUT = 0, accumulator = 0, step counter = 0, busy = 0.
  - Reset asserted mid-operation aborts the operation. No partial result is kept.
- Load (rst=1, load=1 at a rising edge):
  - Capture A into the multiplicand register, sign-extended to WIDTH+2 bits.
  - Initialise the product shift register to {(WIDTH+2) zeros, B, 1'b0}.
  - Clear the step counter, set busy = 1, clear OUT to 0.
  - load has priority over en and over an ongoing iteration.
  - Holding load high for several cycles simply reloads each cycle.
- Iterate (rst=1, load=0, en=1, busy=1 at a rising edge):
  - Examine the low 3 bits {b(2i+1), b(2i), b(2i-1)} of the product register.
  - Booth digit selection:
    - 000, 111 -> 0
    - 001, 010 -> +M
    - 011 -> +2M
    - 100 -> -2M
    - 101, 110 -> -M
  - Add the selected value (WIDTH+2 bits, two's complement) to the upper WIDTH+2 bits of the product register.
  - Arithmetic-shift the whole register right by 2. Increment the counter.
- Completion: on the edge performing step WIDTH/2 (the 16th step for WIDTH=32):
  - Write product bits [2*WIDTH:1] of the updated register to OUT.
  - Clear busy.
- Latency: OUT is valid after exactly WIDTH/2 qualifying edges following the last load edge.
- en=0: freeze all state. Stalls extend latency one-for-one.
- Idle (busy=0): OUT holds its value indefinitely until the next load or reset. Further en pulses have no effect.
- Arithmetic:
  - Full two's-complement arithmetic. The result is exact for all operand pairs, including the most-negative × most-negative case.
  - The WIDTH+2 bit guard prevents overflow of ±2M.
  - No saturation, no overflow flag.
- Operands on A and B are ignored except on load edges.

Decomposition:
- Shared package radix_booth_pkg:
  - WIDTH default.
  - Booth digit encoding constants (ZERO, POS1, POS2, NEG2, NEG1).
  - Step-count constant WIDTH/2 and counter width $clog2(WIDTH/2+1).
- One natural sub-module: booth_r4_digit.
  - Combinational.
  - Inputs: a 3-bit window and the multiplicand.
  - Output: the signed WIDTH+2 bit addend.
- Top level holds the registers, counter and control.

Test Plan:
- Small positives: A=0x00087234, B=0x00000348, load 2 cycles, then ≥16 en cycles -> OUT=0x000000001BB6BAA0.
- Negative × negative: A=0xFFFFFEFD, B=0xFFFFFEFD -> OUT=0x0000000000010609. Mixed sign: A=0x00087234, B=0xFFFFFEFD -> OUT=0xFFFFFFFFF7747564.
- Large mixed sign: A=0x50647236, B=0xB887CAAF -> OUT=0xE98E647F4142AEEA.
- Large negatives: A=0xB887CAAF, B=0x887CAAF3 -> OUT=0x215D8B0A7A419A1D.
- Identity and zero cases:
  - A=0xB887CAAF, B=1 -> 0xFFFFFFFFB887CAAF.
  - A=0, B=0x50647236 -> 0.
  - A=0x80000000, B=0x80000000 -> 0x4000000000000000.
- Control cases:
  - Drop en for 5 cycles mid-run -> same result, 5 cycles later.
  - Pull rst low mid-run -> OUT=0 immediately (asynchronous).
  - Reassert load mid-run -> restart with the new operands.

Source files
------------

// File: rtl/radix_booth_pkg.sv
// Shared constants and Booth radix-4 digit encoding for the sequential signed multiplier.
package radix_booth_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned STEPS_DEF = WIDTH_DEF / 2;
    localparam int unsigned CNT_W_DEF = $clog2(STEPS_DEF + 1);

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG2 = 3'd3,
        NEG1 = 3'd4
    } booth_digit_e;

    // Counter width able to hold 0..width/2.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width / 2 + 1);
    endfunction

    // Map the overlapping 3-bit multiplier window {b(2i+1), b(2i), b(2i-1)} to a digit.
    function automatic booth_digit_e booth_decode(input logic [2:0] win);
        booth_digit_e digit;
        digit = ZERO;
        case (win)
            3'b001, 3'b010: digit = POS1;
            3'b011:         digit = POS2;
            3'b100:         digit = NEG2;
            3'b101, 3'b110: digit = NEG1;
            default:        digit = ZERO;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// Combinational radix-4 Booth digit: selects 0, +-M or +-2M as a WIDTH+2 bit addend.
module booth_r4_digit
    import radix_booth_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [2:0]       win_i,
    input  logic [WIDTH+1:0] mcand_i,
    output logic [WIDTH+1:0] addend_c_o
);

    booth_digit_e     digit_c;
    logic [WIDTH+1:0] mcand_x2_c;

    assign digit_c    = booth_decode(win_i);
    // Guard bits keep 2M representable for the most-negative multiplicand.
    assign mcand_x2_c = {mcand_i[WIDTH:0], 1'b0};

    always_comb begin
        addend_c_o = '0;
        case (digit_c)
            POS1:    addend_c_o = mcand_i;
            POS2:    addend_c_o = mcand_x2_c;
            NEG2:    addend_c_o = -mcand_x2_c;
            NEG1:    addend_c_o = -mcand_i;
            default: addend_c_o = '0;
        endcase
    end

endmodule

// File: rtl/radix_booth_mult.sv
// Sequential signed multiplier retiring one radix-4 Booth digit per enabled clock.
module radix_booth_mult
    import radix_booth_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 load,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   OUT
);

    localparam int unsigned PW    = 2 * WIDTH + 3;
    localparam int unsigned STEPS = WIDTH / 2;
    localparam int unsigned CNT_W = cnt_width(WIDTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [WIDTH+1:0]   mcand_q, mcand_d;
    logic [PW-1:0]      prod_q, prod_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] out_q, out_d;

    logic [WIDTH+1:0]   addend_c;
    logic [WIDTH+1:0]   upper_sum_c;
    logic [PW-1:0]      step_c;

    booth_r4_digit #(
        .WIDTH(WIDTH)
    ) u_digit (
        .win_i     (prod_q[2:0]),
        .mcand_i   (mcand_q),
        .addend_c_o(addend_c)
    );

    // Accumulate into the guarded upper half, then arithmetic shift right by one digit.
    assign upper_sum_c = prod_q[PW-1:WIDTH+1] + addend_c;
    assign step_c      = {{2{upper_sum_c[WIDTH+1]}}, upper_sum_c, prod_q[WIDTH:2]};

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        if (load) begin
            state_d = S_BUSY;
            mcand_d = {{2{A[WIDTH-1]}}, A};
            prod_d  = {{(WIDTH+2){1'b0}}, B, 1'b0};
            cnt_d   = '0;
            out_d   = '0;
        end else if (en && (state_q == S_BUSY)) begin
            prod_d = step_c;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(STEPS - 1)) begin
                out_d   = step_c[2*WIDTH:1];
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign OUT = out_q;

endmodule

// File: tb/tb_radix_booth_mult.sv
// Scoreboard bench for radix_booth_mult: stimulus queues timed expectations, monitors compare.
module tb_radix_booth_mult;

    typedef struct {
        logic [63:0] val;
        int unsigned due;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [63:0] OUT;

    exp_t        sb[$];
    exp_t        rst_sb[$];
    int unsigned cyc = 0;
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    radix_booth_mult #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .load(load),
        .A   (A),
        .B   (B),
        .OUT (OUT)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Timed monitor: checks every expectation whose due cycle has arrived.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            if (e.due != cyc) begin
                n_bad++;
                $display("FAIL %s: check missed, due cycle %0d now %0d", e.name, e.due, cyc);
            end else if (OUT !== e.val) begin
                n_bad++;
                $display("FAIL %s: cycle %0d OUT=%h expected %h", e.name, cyc, OUT, e.val);
            end
        end
    end

    // Asynchronous reset monitor: samples OUT shortly after rst falls, before any clock edge.
    always @(negedge rst) begin
        #1;
        if (rst_sb.size() > 0) begin
            exp_t e;
            e = rst_sb.pop_front();
            n_vec++;
            if (OUT !== e.val) begin
                n_bad++;
                $display("FAIL %s: OUT=%h expected %h after async reset", e.name, OUT, e.val);
            end
        end
    end

    task automatic push(input logic [63:0] val, input int unsigned due, input string name);
        exp_t e;
        e.val = val; e.due = due; e.name = name;
        sb.push_back(e);
    endtask

    task automatic push_rst(input string name);
        exp_t e;
        e.val = '0; e.due = 0; e.name = name;
        rst_sb.push_back(e);
    endtask

    task automatic start_load(input logic [31:0] a, input logic [31:0] b, input int unsigned nload);
        for (int i = 0; i < int'(nload); i++) begin
            @(negedge clk);
            A = a; B = b; load = 1'b1; en = 1'b1;
        end
        @(negedge clk);
        load = 1'b0;
        A = $urandom; B = $urandom;
    endtask

    // One multiply: OUT stays 0 until exactly 16 qualifying edges, then holds under extra en pulses.
    task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp_p,
                           input string name, input int unsigned nload, input int unsigned stall);
        int unsigned l;
        start_load(a, b, nload);
        l = cyc;
        push(64'd0, l + 15 + stall, {name, "_pre"});
        push(exp_p, l + 16 + stall, name);
        push(exp_p, l + 19 + stall, {name, "_hold"});
        for (int j = 0; j < 20 + int'(stall); j++) begin
            en = !(stall != 0 && j >= 5 && j < 5 + int'(stall));
            @(negedge clk);
        end
        en = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        push(64'd0, cyc + 1, "reset_state");
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
        push(64'd0, cyc + 3, "idle_en_after_reset");
        repeat (4) @(negedge clk);
        en = 1'b0;

        do_mult(32'h00087234, 32'h00000348, 64'h000000001BB6BAA0, "small_pos", 2, 0);
        do_mult(32'hFFFFFEFD, 32'hFFFFFEFD, 64'h0000000000010609, "neg_neg", 1, 0);
        do_mult(32'h00087234, 32'hFFFFFEFD, 64'hFFFFFFFFF7747564, "mixed_small", 1, 0);
        do_mult(32'h50647236, 32'hB887CAAF, 64'hE98E647F4142AEEA, "mixed_large", 1, 0);
        do_mult(32'hB887CAAF, 32'h887CAAF3, 64'h215D8B0A7A419A1D, "neg_large", 3, 0);
        do_mult(32'hB887CAAF, 32'h00000001, 64'hFFFFFFFFB887CAAF, "identity", 1, 0);
        do_mult(32'h00000000, 32'h50647236, 64'h0000000000000000, "zero_a", 1, 0);
        do_mult(32'h80000000, 32'h80000000, 64'h4000000000000000, "min_min", 1, 0);
        do_mult(32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000, "max_min", 1, 0);
        do_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001, "m1_m1", 1, 0);
        do_mult(32'h50647236, 32'hB887CAAF, 64'hE98E647F4142AEEA, "stall5", 1, 5);

        // Reset while idle with a result held, then reset mid-run; no result may emerge.
        @(negedge clk);
        #2;
        push_rst("rst_idle_clears_out");
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        start_load(32'hB887CAAF, 32'h887CAAF3, 1);
        en = 1'b1;
        repeat (8) @(negedge clk);
        #2;
        push_rst("rst_mid_run");
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        push(64'd0, cyc + 20, "aborted_no_result");
        repeat (22) @(negedge clk);
        en = 1'b0;

        // Reload mid-run: the earlier operands must leave no trace.
        start_load(32'h50647236, 32'hB887CAAF, 1);
        en = 1'b1;
        repeat (7) @(negedge clk);
        do_mult(32'h00087234, 32'hFFFFFEFD, 64'hFFFFFFFFF7747564, "reload_mid_run", 1, 0);

        for (int k = 0; k < 50 && sb.size() > 0; k++) @(negedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL %s: never checked, due cycle %0d", e.name, e.due);
        end
        while (rst_sb.size() > 0) begin
            exp_t e;
            e = rst_sb.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL %s: reset check never ran", e.name);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
